// File: rtl/vga_timing_core_if.sv
// Pixel-timing bundle between the timing core and the background renderers.
// The master side is the timing core: it receives the pixel enable and drives timing.
interface vga_timing_core_if #(
    parameter int FCNT_W = 8
);
    logic              ce;
    logic              hsync;
    logic              vsync;
    logic [9:0]        x_px;
    logic [9:0]        y_px;
    logic              activevideo;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        input  ce,
        output hsync, vsync, x_px, y_px, activevideo, line_start, frame_start, frame_cnt
    );

    modport slave (
        output ce,
        input  hsync, vsync, x_px, y_px, activevideo, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_core.sv
// VGA pixel-timing generator: x/y counters, syncs, active flag, strobes, frame count.
// Every output is a flop decoded from the next-state counters, so all outputs share one edge.
module vga_timing_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int FCNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    vga_timing_core_if.master  tim
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]        r_x, r_y, w_x_nxt, w_y_nxt;
    logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
    logic              r_hsync, r_vsync, r_active, r_line, r_frame;
    logic              w_hs_act, w_vs_act;

    // ">=" on the wrap checks also folds any out-of-range count back to 0
    always_comb begin
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_fcnt_nxt = r_fcnt;
        if (reset) begin
            w_x_nxt    = '0;
            w_y_nxt    = '0;
            w_fcnt_nxt = '0;
        end else if (tim.ce) begin
            if (r_x >= H_LAST) begin
                w_x_nxt = '0;
                if (r_y >= V_LAST) begin
                    w_y_nxt    = '0;
                    w_fcnt_nxt = r_fcnt + 1'b1;
                end else begin
                    w_y_nxt = r_y + 10'd1;
                end
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end
    end

    assign w_hs_act = (w_x_nxt >= HS_START) && (w_x_nxt < HS_END);
    assign w_vs_act = (w_y_nxt >= VS_START) && (w_y_nxt < VS_END);

    // Reset is folded into the next-state terms, so one unconditional register bank suffices
    always_ff @(posedge clk) begin
        r_x      <= w_x_nxt;
        r_y      <= w_y_nxt;
        r_fcnt   <= w_fcnt_nxt;
        r_hsync  <= w_hs_act ? HS_POL : ~HS_POL;
        r_vsync  <= w_vs_act ? VS_POL : ~VS_POL;
        r_active <= (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
        r_line   <= (w_x_nxt == 10'd0);
        r_frame  <= (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
    end

    assign tim.x_px        = r_x;
    assign tim.y_px        = r_y;
    assign tim.frame_cnt   = r_fcnt;
    assign tim.hsync       = r_hsync;
    assign tim.vsync       = r_vsync;
    assign tim.activevideo = r_active;
    assign tim.line_start  = r_line;
    assign tim.frame_start = r_frame;
endmodule
